// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI master controller and its SCLK generator.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        NEXT,
        HOLD
    } spi_state_e;

    localparam int SPI_DATA_W = 8;
    localparam int SPI_EDGES  = 16;
    localparam int SPI_DIV_W  = 8;

endpackage

// File: rtl/spi_sclk_gen.sv
// Clock divider and SCLK edge sequencer: half-period strobes, leading/trailing
// edge classification and a done strobe on the 16th edge of a byte.
module spi_sclk_gen
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic shift_i,
    input  logic cpol_i,
    output logic strobe_o,
    output logic lead_o,
    output logic trail_o,
    output logic done_o,
    output logic sclk_o
);

    localparam logic [SPI_DIV_W-1:0] DIV_LAST = SPI_DIV_W'(CLK_DIV - 1);

    logic [SPI_DIV_W-1:0] div_q, div_d;
    logic [3:0]           edge_q, edge_d;
    logic                 sclk_q, sclk_d;

    always_comb begin
        strobe_o = en_i && (div_q == DIV_LAST);
        div_d    = '0;
        if (en_i && !strobe_o) begin
            div_d = div_q + 1'b1;
        end

        // Outside SHIFT the edge counter is held clear so each byte starts at edge 0.
        edge_d = '0;
        sclk_d = cpol_i;
        if (shift_i) begin
            edge_d = edge_q;
            sclk_d = sclk_q;
            if (strobe_o) begin
                edge_d = edge_q + 1'b1;
                sclk_d = ~sclk_q;
            end
        end

        lead_o  = shift_i && strobe_o && !edge_q[0];
        trail_o = shift_i && strobe_o && edge_q[0];
        done_o  = trail_o && (edge_q == 4'(SPI_EDGES - 1));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q  <= '0;
            edge_q <= '0;
            sclk_q <= cpol_i;
        end else begin
            div_q  <= div_d;
            edge_q <= edge_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk_o = sclk_q;

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master transaction sequencer: byte-wide valid/ready in, SCLK/CS/MOSI out.
// Define SPI_MASTER_MODE_EN to add cpol_i/cpha_i ports; otherwise mode 0 is fixed.
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
`ifdef SPI_MASTER_MODE_EN
    input  logic                  cpol_i,
    input  logic                  cpha_i,
`endif
    input  logic                  tx_valid_i,
    output logic                  tx_ready_o,
    input  logic [SPI_DATA_W-1:0] tx_data_i,
    input  logic                  tx_last_i,
    output logic                  rx_valid_o,
    output logic [SPI_DATA_W-1:0] rx_data_o,
    output logic                  busy_o,
    output logic                  sclk_o,
    output logic                  cs_n_o,
    output logic                  mosi_o,
    input  logic                  miso_i
);

    spi_state_e state_q, state_d;

    logic [SPI_DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, rx_data_q, rx_data_d;
    logic last_q, last_d, mosi_q, mosi_d, cs_n_q, cs_n_d, rx_valid_q, rx_valid_d;
    logic accept, gen_en, gen_shift, strobe, lead, trail, done, sample, drive;
    logic cpol, cpha;

`ifdef SPI_MASTER_MODE_EN
    logic cpol_q, cpol_d, cpha_q, cpha_d;

    // Mode is frozen for the whole transaction; only IDLE follows the inputs.
    always_comb begin
        cpol_d = cpol_q;
        cpha_d = cpha_q;
        if (state_q == IDLE) begin
            cpol_d = cpol_i;
            cpha_d = cpha_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cpol_q <= cpol_i;
            cpha_q <= cpha_i;
        end else begin
            cpol_q <= cpol_d;
            cpha_q <= cpha_d;
        end
    end

    assign cpol = cpol_q;
    assign cpha = cpha_q;
`else
    assign cpol = 1'b0;
    assign cpha = 1'b0;
`endif

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .en_i     (gen_en),
        .shift_i  (gen_shift),
        .cpol_i   (cpol),
        .strobe_o (strobe),
        .lead_o   (lead),
        .trail_o  (trail),
        .done_o   (done),
        .sclk_o   (sclk_o)
    );

    assign tx_ready_o = (state_q == IDLE) || (state_q == NEXT);
    assign busy_o     = (state_q != IDLE);
    assign accept     = tx_ready_o && tx_valid_i;
    assign gen_en     = (state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD);
    assign gen_shift  = (state_q == SHIFT);
    assign sample     = cpha ? trail : lead;
    assign drive      = cpha ? lead : trail;

    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        last_d     = last_q;
        mosi_d     = mosi_q;
        rx_valid_d = 1'b0;
        rx_data_d  = rx_data_q;

        case (state_q)
            IDLE:    if (accept) state_d = SETUP;
            SETUP:   if (strobe) state_d = SHIFT;
            SHIFT: begin
                if (done) begin
                    state_d    = last_q ? HOLD : NEXT;
                    rx_valid_d = 1'b1;
                    // With CPHA=1 the final bit is sampled on this same edge.
                    rx_data_d  = cpha ? {rx_q[SPI_DATA_W-2:0], miso_i} : rx_q;
                end
            end
            NEXT:    if (accept) state_d = SHIFT;
            HOLD:    if (strobe) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (accept) begin
            tx_d   = tx_data_i;
            last_d = tx_last_i;
            if (!cpha) begin
                mosi_d = tx_data_i[SPI_DATA_W-1];
            end
        end
        if (sample) begin
            rx_d = {rx_q[SPI_DATA_W-2:0], miso_i};
        end
        if (drive) begin
            mosi_d = cpha ? tx_q[SPI_DATA_W-1] : tx_q[SPI_DATA_W-2];
            tx_d   = {tx_q[SPI_DATA_W-2:0], 1'b0};
        end

        // CS stays low through the HOLD->IDLE cycle, rising one cycle later.
        cs_n_d = (state_q == IDLE) && (state_d == IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            last_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
        end
    end

    always_ff @(posedge clk_i) begin
        tx_q <= tx_d;
        rx_q <= rx_d;
    end

    assign cs_n_o     = cs_n_q;
    assign mosi_o     = mosi_q;
    assign rx_valid_o = rx_valid_q;
    assign rx_data_o  = rx_data_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: CLK_DIV=2 instance with a slave model or
// loopback, plus a CLK_DIV=1 loopback instance.
module tb_spi_master_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       tv2, tr2, tl2, rv2, busy2, sclk2, cs2, mosi2, miso2;
    logic [7:0] td2, rd2;
    logic       tv1, tr1, tl1, rv1, busy1, sclk1, cs1, mosi1;
    logic [7:0] td1, rd1;
    logic       cpol_tb, cpha_tb, lb2;
    logic [7:0] slave_q, mosi_cap;

    int         cyc, total, passed;
    int         rx_cyc[$];
    logic [7:0] rx_dat[$];
    int         rx1_cnt, rx1_cyc;
    logic [7:0] rx1_dat;
    int         cs_rise, gap_bad, cs_high_cnt, acc_cyc;
    logic       cs_prev, watch_gap, watch_cs;

    assign miso2 = lb2 ? mosi2 : slave_q[7];

    spi_master_ctrl #(.CLK_DIV(2)) dut2 (
        .clk_i(clk), .rst_i(rst),
`ifdef SPI_MASTER_MODE_EN
        .cpol_i(cpol_tb), .cpha_i(cpha_tb),
`endif
        .tx_valid_i(tv2), .tx_ready_o(tr2), .tx_data_i(td2), .tx_last_i(tl2),
        .rx_valid_o(rv2), .rx_data_o(rd2), .busy_o(busy2), .sclk_o(sclk2),
        .cs_n_o(cs2), .mosi_o(mosi2), .miso_i(miso2)
    );

    spi_master_ctrl #(.CLK_DIV(1)) dut1 (
        .clk_i(clk), .rst_i(rst),
`ifdef SPI_MASTER_MODE_EN
        .cpol_i(1'b0), .cpha_i(1'b0),
`endif
        .tx_valid_i(tv1), .tx_ready_o(tr1), .tx_data_i(td1), .tx_last_i(tl1),
        .rx_valid_o(rv1), .rx_data_o(rd1), .busy_o(busy1), .sclk_o(sclk1),
        .cs_n_o(cs1), .mosi_o(mosi1), .miso_i(mosi1)
    );

    // Slave model: shifts on falling SCLK, captures MOSI on rising SCLK.
    always @(negedge sclk2) slave_q = {slave_q[6:0], 1'b0};
    always @(posedge sclk2) mosi_cap = {mosi_cap[6:0], mosi2};

    always @(negedge clk) begin
        if (rv2) begin
            rx_cyc.push_back(cyc);
            rx_dat.push_back(rd2);
        end
        if (cs2 && !cs_prev) cs_rise = cyc;
        cs_prev = cs2;
        if (watch_cs && cs2) cs_high_cnt++;
        if (watch_gap && !(cs2 == 1'b0 && sclk2 == cpol_tb && tr2 == 1'b1)) gap_bad++;
        if (rv1) begin
            rx1_cnt++;
            rx1_dat = rd1;
            rx1_cyc = cyc;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input bit sel, input logic [7:0] d, input logic last, input bit keep);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        if (sel) begin td1 = d; tl1 = last; tv1 = 1'b1; end
        else     begin td2 = d; tl2 = last; tv2 = 1'b1; end
        while (!acc && n < 300) begin
            @(negedge clk);
            acc = sel ? tr1 : tr2;
            tick();
            n++;
        end
        if (!keep) begin tv1 = 1'b0; tv2 = 1'b0; end
        acc_cyc = cyc - 1;
        chk("accept", acc, 1);
    endtask

    task automatic clear_mon();
        rx_cyc.delete();
        rx_dat.delete();
        cs_rise = -1;
        rx1_cnt = 0;
    endtask

    typedef struct {
        logic [7:0] tx;
        logic [7:0] slave;
        logic [7:0] exp_rx;
        logic [7:0] exp_mosi;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{tx: 8'hA5, slave: 8'h3C, exp_rx: 8'h3C, exp_mosi: 8'hA5};
        vecs[1] = '{tx: 8'h00, slave: 8'hFF, exp_rx: 8'hFF, exp_mosi: 8'h00};
        vecs[2] = '{tx: 8'hFF, slave: 8'h00, exp_rx: 8'h00, exp_mosi: 8'hFF};
        vecs[3] = '{tx: 8'h81, slave: 8'h7E, exp_rx: 8'h7E, exp_mosi: 8'h81};

        total = 0; passed = 0; cyc = 0;
        rst = 1'b1; tv1 = 0; tv2 = 0; tl1 = 0; tl2 = 0; td1 = 0; td2 = 0;
        cpol_tb = 0; cpha_tb = 0; lb2 = 0; slave_q = 0; mosi_cap = 0;
        cs_prev = 1'b1; watch_gap = 0; watch_cs = 0; gap_bad = 0; cs_high_cnt = 0;
        clear_mon();
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(2);

        chk("rst_cs_n", cs2, 1);
        chk("rst_sclk", sclk2, 0);
        chk("rst_mosi", mosi2, 0);
        chk("rst_rx_valid", rv2, 0);
        chk("rst_rx_data", rd2, 0);
        chk("rst_ready", tr2, 1);
        chk("rst_busy", busy2, 0);

        // Single-byte mode-0 transfers, CLK_DIV=2
        for (int i = 0; i < 4; i++) begin
            slave_q = vecs[i].slave;
            mosi_cap = 8'h00;
            clear_mon();
            cyc = 0;
            send(1'b0, vecs[i].tx, 1'b1, 1'b0);
            chk("busy_after_accept", busy2, 1);
            wait_cycles(45);
            chk("rx_count", rx_cyc.size(), 1);
            if (rx_cyc.size() > 0) begin
                chk("rx_cycle", rx_cyc[0], 35);
                chk("rx_data", rx_dat[0], vecs[i].exp_rx);
            end
            chk("cs_rise_cycle", cs_rise, 38);
            chk("mosi_bits", mosi_cap, vecs[i].exp_mosi);
        end

        // Burst of three with tx_valid held, loopback
        lb2 = 1'b1;
        clear_mon();
        cs_high_cnt = 0;
        cyc = 0;
        send(1'b0, 8'h01, 1'b0, 1'b1);
        watch_cs = 1'b1;
        send(1'b0, 8'h02, 1'b0, 1'b1);
        send(1'b0, 8'h03, 1'b1, 1'b0);
        wait_cycles(33);
        watch_cs = 1'b0;
        wait_cycles(10);
        chk("burst_rx_count", rx_cyc.size(), 3);
        chk("burst_cs_high", cs_high_cnt, 0);
        if (rx_cyc.size() == 3) begin
            chk("burst_gap1", rx_cyc[1] - rx_cyc[0], 33);
            chk("burst_gap2", rx_cyc[2] - rx_cyc[1], 33);
            chk("burst_d0", rx_dat[0], 8'h01);
            chk("burst_d1", rx_dat[1], 8'h02);
            chk("burst_d2", rx_dat[2], 8'h03);
        end

        // Requester stall in NEXT for 50 cycles
        clear_mon();
        gap_bad = 0;
        cyc = 0;
        send(1'b0, 8'h11, 1'b0, 1'b0);
        wait_cycles(36);
        watch_gap = 1'b1;
        wait_cycles(50);
        watch_gap = 1'b0;
        chk("stall_gap", gap_bad, 0);
        send(1'b0, 8'h22, 1'b1, 1'b0);
        wait_cycles(45);
        chk("stall_rx_count", rx_cyc.size(), 2);
        if (rx_cyc.size() == 2) begin
            chk("stall_rx_cycle", rx_cyc[1], acc_cyc + 33);
            chk("stall_rx_data", rx_dat[1], 8'h22);
        end

        // Reset mid-SHIFT after the 7th SCLK edge
        lb2 = 1'b0;
        slave_q = 8'hAA;
        clear_mon();
        cyc = 0;
        send(1'b0, 8'h55, 1'b1, 1'b0);
        wait_cycles(16);
        chk("edge7_sclk", sclk2, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_cs_n", cs2, 1);
        chk("midrst_sclk", sclk2, 0);
        chk("midrst_mosi", mosi2, 0);
        chk("midrst_busy", busy2, 0);
        chk("midrst_rx_data", rd2, 0);
        wait_cycles(40);
        chk("midrst_no_rx", rx_cyc.size(), 0);
        slave_q = 8'h96;
        mosi_cap = 8'h00;
        cyc = 0;
        send(1'b0, 8'hFF, 1'b1, 1'b0);
        wait_cycles(45);
        chk("postrst_rx_count", rx_cyc.size(), 1);
        if (rx_cyc.size() == 1) chk("postrst_rx_data", rx_dat[0], 8'h96);
        chk("postrst_mosi", mosi_cap, 8'hFF);

        // CLK_DIV=1 loopback
        clear_mon();
        cyc = 0;
        send(1'b1, 8'h5A, 1'b1, 1'b0);
        wait_cycles(30);
        chk("div1_rx_count", rx1_cnt, 1);
        chk("div1_rx_data", rx1_dat, 8'h5A);
        chk("div1_rx_cycle", rx1_cyc, 18);
        chk("div1_cs_n", cs1, 1);

`ifdef SPI_MASTER_MODE_EN
        // Mode 3 loopback
        cpol_tb = 1'b1;
        cpha_tb = 1'b1;
        wait_cycles(3);
        chk("mode3_idle_sclk", sclk2, 1);
        lb2 = 1'b1;
        mosi_cap = 8'h00;
        clear_mon();
        cyc = 0;
        send(1'b0, 8'hC3, 1'b1, 1'b0);
        wait_cycles(45);
        chk("mode3_rx_count", rx_cyc.size(), 1);
        if (rx_cyc.size() == 1) chk("mode3_rx_data", rx_dat[0], 8'hC3);
        chk("mode3_mosi_rising", mosi_cap, 8'hC3);
        chk("mode3_idle_after", sclk2, 1);
        cpol_tb = 1'b0;
        cpha_tb = 1'b0;
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
